// File: rtl/gnrl_pulse_train_pkg.sv
// rtl/gnrl_pulse_train_pkg.sv - shared state encoding and default widths for the pulse-train generator
package gnrl_pulse_train_pkg;

  // Default widths for the length inputs/phase counter and the pulse count
  localparam int CNT_WIDTH_DEF = 32;
  localparam int NUM_WIDTH_DEF = 16;

  // One-hot controller states
  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_HIGH   = 4'b0010,
    S_LOW    = 4'b0100,
    S_FINISH = 4'b1000
  } state_e;

endpackage

// File: rtl/gnrl_phase_counter.sv
// rtl/gnrl_phase_counter.sv - loadable down-counter with zero flag timing each high/low phase
module gnrl_phase_counter
  import gnrl_pulse_train_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 load,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Load wins over decrement; holding at zero keeps the counter from wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gnrl_pulse_train.sv
// rtl/gnrl_pulse_train.sv - burst pulse-train generator; optional ABORT input under PULSE_TRAIN_ABORT_EN
module gnrl_pulse_train
  import gnrl_pulse_train_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int NUM_WIDTH = NUM_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 TRIG,
  input  logic [CNT_WIDTH-1:0] HIGH_LEN,
  input  logic [CNT_WIDTH-1:0] LOW_LEN,
  input  logic [NUM_WIDTH-1:0] NUM_PULSE,
  output logic                 PULSE_OUT,
  output logic                 BUSY,
  output logic                 DONE
`ifdef PULSE_TRAIN_ABORT_EN
  ,
  input  logic                 ABORT
`endif
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] high_len_q, high_len_d;
  logic [CNT_WIDTH-1:0] low_len_q, low_len_d;
  logic [NUM_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
  logic                 pulse_out_q, pulse_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 ph_load;
  logic                 ph_en;
  logic [CNT_WIDTH-1:0] ph_load_val;
  logic                 ph_zero;
  logic                 abort_req;
  logic [CNT_WIDTH-1:0] high_eff;
  logic [CNT_WIDTH-1:0] low_eff;

`ifdef PULSE_TRAIN_ABORT_EN
  assign abort_req = ABORT;
`else
  assign abort_req = 1'b0;
`endif

  // Zero-length phases run as one cycle so the counter load never underflows
  assign high_eff = (HIGH_LEN == '0) ? CNT_WIDTH'(1) : HIGH_LEN;
  assign low_eff  = (LOW_LEN == '0) ? CNT_WIDTH'(1) : LOW_LEN;

  gnrl_phase_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_phase_counter (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (ph_load),
    .en       (ph_en),
    .load_val (ph_load_val),
    .zero     (ph_zero)
  );

  // Next-state, counter control and outputs derived from the next state so they are registered
  always_comb begin
    state_d     = state_q;
    high_len_d  = high_len_q;
    low_len_d   = low_len_q;
    pulse_cnt_d = pulse_cnt_q;
    ph_load     = 1'b0;
    ph_en       = 1'b0;
    ph_load_val = high_len_q - CNT_WIDTH'(1);
    unique case (state_q)
      S_IDLE: begin
        if (TRIG) begin
          high_len_d  = high_eff;
          low_len_d   = low_eff;
          pulse_cnt_d = NUM_PULSE;
          if (NUM_PULSE != '0) begin
            state_d     = S_HIGH;
            ph_load     = 1'b1;
            ph_load_val = high_eff - CNT_WIDTH'(1);
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_HIGH: begin
        if (abort_req) begin
          state_d = S_FINISH;
        end else if (ph_zero) begin
          pulse_cnt_d = pulse_cnt_q - NUM_WIDTH'(1);
          if (pulse_cnt_q == NUM_WIDTH'(1)) begin
            state_d = S_FINISH;
          end else begin
            state_d     = S_LOW;
            ph_load     = 1'b1;
            ph_load_val = low_len_q - CNT_WIDTH'(1);
          end
        end else begin
          ph_en = 1'b1;
        end
      end
      S_LOW: begin
        if (abort_req) begin
          state_d = S_FINISH;
        end else if (ph_zero) begin
          state_d     = S_HIGH;
          ph_load     = 1'b1;
          ph_load_val = high_len_q - CNT_WIDTH'(1);
        end else begin
          ph_en = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    pulse_out_d = (state_d == S_HIGH);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
  end

  // State, latched burst parameters and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      high_len_q  <= '0;
      low_len_q   <= '0;
      pulse_cnt_q <= '0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_len_q  <= high_len_d;
      low_len_q   <= low_len_d;
      pulse_cnt_q <= pulse_cnt_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign PULSE_OUT = pulse_out_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: doc/gnrl_pulse_train.md
# gnrl_pulse_train

Pulse-train generator placed directly downstream of the general delayed pulser. It converts the pulser's single-cycle delayed activation pulse into a burst of NUM_PULSE rectangular pulses with programmable high and low widths. The burst drives the antenna modulation switch. BUSY and DONE status outputs go to the sequencing logic.

## Interface
- CNT_WIDTH, default 32: width of HIGH_LEN, LOW_LEN and the phase counter.
- NUM_WIDTH, default 16: width of NUM_PULSE and the pulse counter.

- CLK  in  1: system clock; all state changes on rising edge.
- RESET  in  1: reset RESET, asynchronous, active-high; clock CLK.
- TRIG  in  1: start request, nominally the 1-cycle pulse from the delayed pulser; level-sensitive, sampled only in IDLE.
- HIGH_LEN  in  CNT_WIDTH: high-phase length in cycles; 0 is treated as 1.
- LOW_LEN  in  CNT_WIDTH: low-phase length between pulses; 0 is treated as 1.
- NUM_PULSE  in  NUM_WIDTH: pulses per burst; 0 means an empty burst.
- PULSE_OUT  out  1: registered pulse train.
- BUSY  out  1: burst in progress, from the first cycle after acceptance through the DONE cycle.
- DONE  out  1: 1-cycle completion strobe.
- ABORT  in  1: exists only with PULSE_TRAIN_ABORT_EN.

## Operation
- State machine, one-hot: IDLE, HIGH, LOW, FINISH.
- Reset value of all outputs is 0. State resets to IDLE and all counters reset to 0. RESET mid-burst clears PULSE_OUT immediately (asynchronously).
- IDLE:
  - On TRIG=1, latch HIGH_LEN, LOW_LEN and NUM_PULSE. Zero lengths are forced to 1 at latch time.
  - If NUM_PULSE≠0, go to HIGH. Load the phase counter with H-1 and the pulse counter with NUM_PULSE.
  - If NUM_PULSE=0, go to FINISH.
- HIGH:
  - PULSE_OUT=1 while in this state. The phase counter decrements each cycle.
  - When the phase counter reaches 0, decrement the pulse counter.
  - If the pulse counter was 1, go to FINISH. No trailing low phase follows the last pulse.
  - Otherwise go to LOW and load the phase counter with L-1.
- LOW: PULSE_OUT=0. When the phase counter reaches 0, go to HIGH and load the phase counter with H-1.
- FINISH: DONE=1 for one cycle, then go to IDLE.
- TRIG outside IDLE is ignored, including TRIG held high for the whole burst. Retrigger requires TRIG=1 while in IDLE.
- Input length and count changes during a burst have no effect until the next acceptance.
- Counter arithmetic is unsigned. The down-counters never wrap, because they are reloaded before they reach underflow.

## Timing
- Let TRIG be sampled at edge t, with H and L the effective lengths and N≥1.
- PULSE_OUT rises on edge t+1.
- Pulse k (k=0..N-1) is high for cycles t+1+k(H+L) through t+k(H+L)+H.
- The last high cycle is t+N·H+(N-1)·L. DONE is high on the following cycle.
- For N=0, DONE is high in cycle t+1 and PULSE_OUT never rises.
- BUSY covers cycle t+1 through the DONE cycle inclusive.
- The earliest new acceptance is the cycle after DONE.
- Period is exactly H+L with no gaps or extra cycles.

## Configuration
- Macro: PULSE_TRAIN_ABORT_EN.
- Defined:
  - ABORT port present.
  - ABORT=1 in HIGH or LOW forces FINISH on the next edge. PULSE_OUT goes to 0 on that edge and DONE pulses once.
  - ABORT in IDLE or FINISH has no effect.
  - TRIG and ABORT in the same IDLE cycle: TRIG wins.
- Undefined: no ABORT port; bursts always run to completion.

## Structure
- Package gnrl_pulse_train_pkg:
  - one-hot state constants S_IDLE, S_HIGH, S_LOW, S_FINISH;
  - default width constants for CNT_WIDTH and NUM_WIDTH.
- One sub-module, gnrl_phase_counter: loadable CNT_WIDTH down-counter with load, enable and zero flag. It is used for the phase counter only; the pulse counter stays inline.

## Test plan
- H=3, L=2, N=4, TRIG at t: PULSE_OUT high at t+1..t+3, t+6..t+8, t+11..t+13, t+16..t+18; DONE at t+19 only; BUSY high t+1..t+19.
- N=0: DONE at t+1, PULSE_OUT stays 0, BUSY high 1 cycle.
- H=0, L=0, N=3: treated as H=1, L=1; PULSE_OUT alternates 1,0,1,0,1; DONE at t+6.
- TRIG held high 30 cycles with H=2, L=2, N=2: exactly one burst during BUSY; a second burst starts the cycle after DONE.
- RESET asserted mid-HIGH of pulse 2: PULSE_OUT, BUSY and DONE all 0 immediately; after release, the next TRIG starts a clean burst.
- With PULSE_TRAIN_ABORT_EN, H=5, L=5, N=10, ABORT in the third cycle of pulse 1: PULSE_OUT 0 on the next edge, single DONE, then IDLE.
